// File: rtl/select_line_sequencer.sv
// ============================================================================
// select_line_sequencer : guarded, polarity-configurable one-hot select driver
// Revision 1.0
// ============================================================================
`default_nettype none

module select_line_sequencer #(
  parameter int ADDR_W     = 4,
  parameter int NUM_LINES  = 16,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    addrBus,
  input  logic                 req,
  input  logic                 addrSel,
  output logic [NUM_LINES-1:0] selectLine,
  output logic                 busy,
  output logic                 done,
  output logic                 addrErr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ASSERT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [NUM_LINES-1:0] C_INACTIVE  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [ADDR_W:0]      C_NUM_LINES = (ADDR_W+1)'(NUM_LINES);
  localparam logic [3:0]           C_SETUP     = 4'(SETUP_CYC);
  localparam logic [3:0]           C_HOLD      = 4'(HOLD_CYC);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [NUM_LINES-1:0]   sel_q, sel_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [NUM_LINES-1:0]   onehot;
  logic [NUM_LINES-1:0]   line_on;
  logic                   addr_ok;

  // The width-extended compare stays valid when NUM_LINES == 2**ADDR_W.
  assign addr_ok = ({1'b0, addrBus} < C_NUM_LINES);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

  assign line_on = (ACTIVE_LOW != 0) ? ~onehot : onehot;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        sel_d = C_INACTIVE;
        if (req) begin
          if (addr_ok) begin
            addr_d  = addrBus;
            cnt_d   = C_SETUP;
            state_d = S_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_SETUP: begin
        sel_d = C_INACTIVE;
        if (!addrSel) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          sel_d   = line_on;
          state_d = S_ASSERT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ASSERT: begin
        sel_d = line_on;
        if (!addrSel) begin
          cnt_d   = C_HOLD;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        // addrSel is deliberately not looked at: a started hold always runs out.
        if (cnt_q == 4'd0) begin
          sel_d   = C_INACTIVE;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          sel_d = line_on;
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        sel_d   = C_INACTIVE;
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      sel_q   <= C_INACTIVE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign selectLine = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign addrErr    = err_q;

endmodule

`default_nettype wire

// File: doc/select_line_sequencer.md
SELECT_LINE_SEQUENCER -- requirements
Module: select_line_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4, address bus width in bits (1..8).
REQ-002 Parameter NUM_LINES, default 16, number of select lines (2..2**ADDR_W).
REQ-003 Parameter SETUP_CYC, default 2, guard cycles between request and line assertion (0..15).
REQ-004 Parameter HOLD_CYC, default 1, cycles a line stays active after release (0..15).
REQ-005 Parameter ACTIVE_LOW, default 1; 1 = selected line driven 0, others 1; 0 = inverse polarity.
REQ-006 The clock and reset ports SHALL be a single clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-007 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-008 Port rst_n, input, 1, asynchronous active-low reset.
REQ-009 Port addrBus, input, ADDR_W, target line index, sampled only on an accepted request.
REQ-010 Port req, input, 1, request strobe, sampled in IDLE only.
REQ-011 Port addrSel, input, 1, keep-select level; high holds the selected line active.
REQ-012 Port selectLine, output, NUM_LINES, registered select lines.
REQ-013 Port busy, output, 1, high from acceptance until return to IDLE.
REQ-014 Port done, output, 1, one-cycle pulse on normal completion.
REQ-015 Port addrErr, output, 1, one-cycle pulse on out-of-range address.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ASSERT and HOLD; all outputs are registered, glitch-free, and at most one line is active at any time.
REQ-017 IDLE: on an edge sampling req=1 with addrBus < NUM_LINES, latch addrBus, load the counter with SETUP_CYC, go to SETUP and set busy=1.
REQ-018 IDLE: on an edge sampling req=1 with addrBus >= NUM_LINES, stay in IDLE, keep busy=0, assert no line, and pulse addrErr for exactly one cycle.
REQ-019 SETUP: all lines inactive; the counter decrements each edge; at count 0, go to ASSERT and drive the latched line active.
REQ-020 The selected line SHALL become active exactly SETUP_CYC+1 edges after the edge that accepted req (1 edge when SETUP_CYC=0).
REQ-021 SETUP: an edge sampling addrSel=0 SHALL abort to IDLE; no line is asserted, busy clears on that edge, and done does not pulse.
REQ-022 ASSERT: the line stays active while addrSel=1, with no timeout; on an edge sampling addrSel=0, load the counter with HOLD_CYC and go to HOLD.
REQ-023 HOLD: the line stays active and the counter decrements; the line deasserts, busy clears and done pulses, all on the same edge, exactly HOLD_CYC+1 edges after addrSel=0 was sampled in ASSERT.
REQ-024 HOLD: a return of addrSel to 1 SHALL be ignored; the hold sequence always completes.
REQ-025 req and addrBus changes while busy=1 SHALL be ignored: no queuing, no line change, no addrErr.
REQ-026 A req accepted on the same edge that busy clears is impossible; the earliest new acceptance is the edge after busy=0 is visible.
REQ-027 Counter width SHALL be 4 bits; it never wraps (it loads, then decrements to 0 only).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, all selectLine bits inactive (all 1 if ACTIVE_LOW=1, else all 0), and busy=0, done=0, addrErr=0, counter=0, latched address=0, regardless of current state.
REQ-029 After rst_n deasserts, the first edge SHALL be able to accept a request.

Verification
REQ-030 Defaults; addrBus=5, req at edge 0, addrSel=1 -> busy=1 after edge 0, selectLine=16'hFFDF after edge 3; addrSel=0 sampled at edge 10 -> selectLine=16'hFFFF, busy=0 and done=1 after edge 12, done=0 after edge 13.
REQ-031 NUM_LINES=12, addrBus=13, req=1 -> addrErr=1 for one cycle, busy stays 0, selectLine stays 12'hFFF.
REQ-032 Defaults; req at edge 0, addrSel=0 at edge 1 -> IDLE, selectLine never leaves 16'hFFFF, done never pulses, busy=0 after edge 1.
REQ-033 Defaults; during ASSERT on line 2, pulse req with addrBus=9 -> selectLine stays 16'hFFFB, and addrErr and done stay 0.
REQ-034 Defaults; rst_n driven low mid-ASSERT, between clock edges -> selectLine=16'hFFFF and busy=0 without waiting for a clock edge.
REQ-035 ACTIVE_LOW=0, SETUP_CYC=0, HOLD_CYC=0; addrBus=0, req at edge 0 -> selectLine=16'h0001 after edge 1; addrSel=0 sampled at edge 5 -> selectLine=16'h0000 and done=1 after edge 6.
